msi_irq_scheduler: RTL

//  Shares the single PCIe MSI request/grant handshake of the AXI PCIe core among N_SRC

---
 rtl/msi_irq_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/msi_irq_scheduler.sv
// Round-robin arbiter sharing one PCIe MSI request/grant handshake
// among N_SRC level interrupt sources, with edge-latched pending events.
module msi_irq_scheduler #(
  parameter int N_SRC      = 4,
  parameter int VEC_BASE   = 0,
  parameter int GAP_CYCLES = 4
) (
  input  logic             axi_clk_pcie,
  input  logic             sys_resetn,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [N_SRC-1:0] irq_mask,
  input  logic             msi_enabled,
  input  logic             msi_grant,
  output logic             msi_request,
  output logic [4:0]       msi_vector_num,
  output logic [N_SRC-1:0] pending_o
);

  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GAP
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [N_SRC-1:0] r_irq_p;
  logic [N_SRC-1:0] r_pend;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_sel;
  logic             r_req;
  logic [4:0]       r_vec;
  logic [7:0]       r_cnt;

  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_elig;
  logic [N_SRC-1:0] w_clr;
  logic [IW-1:0]    w_pick;
  logic             w_any;
  logic [4:0]       w_vec;
  logic [IW-1:0]    w_ptr_n;
  logic [IW-1:0]    w_sel_n;
  logic             w_req_n;
  logic [4:0]       w_vec_n;
  logic [7:0]       w_cnt_n;

  function automatic logic [IW-1:0] wrap(
    input logic [IW-1:0] p,
    input int            i
  );
    int s;
    s = int'(p) + i;
    if (s >= N_SRC) s = s - N_SRC;
    return IW'(s);
  endfunction

  assign w_rise = irq_src & ~r_irq_p;
  assign w_elig = r_pend & ~irq_mask;

  // First eligible source at or above the RR pointer, wrapping to 0
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!w_any && w_elig[wrap(r_ptr, i)]) begin
        w_any  = 1'b1;
        w_pick = wrap(r_ptr, i);
      end
    end
  end

  assign w_vec = 5'(VEC_BASE + int'(w_pick));

  always_comb begin
    w_clr = '0;
    if (r_state == S_REQ && msi_grant) w_clr[r_sel] = 1'b1;
  end

  always_comb begin
    w_state_n = r_state;
    w_req_n   = r_req;
    w_vec_n   = r_vec;
    w_sel_n   = r_sel;
    w_ptr_n   = r_ptr;
    w_cnt_n   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (msi_enabled && w_any) begin
          w_state_n = S_REQ;
          w_req_n   = 1'b1;
          w_sel_n   = w_pick;
          w_vec_n   = w_vec;
        end
      end
      S_REQ: begin
        // Grant wins over a simultaneous enable drop
        if (msi_grant) begin
          w_req_n = 1'b0;
          w_ptr_n = wrap(r_sel, 1);
          if (GAP_CYCLES == 0) begin
            w_state_n = S_IDLE;
          end else begin
            w_state_n = S_GAP;
            w_cnt_n   = 8'(GAP_CYCLES);
          end
        end else if (!msi_enabled) begin
          w_req_n   = 1'b0;
          w_state_n = S_IDLE;
        end
      end
      S_GAP: begin
        if (r_cnt <= 8'd1) begin
          w_state_n = S_IDLE;
          w_cnt_n   = 8'd0;
        end else begin
          w_cnt_n = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_req_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge axi_clk_pcie or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_state <= S_IDLE;
      r_irq_p <= '0;
      r_pend  <= '0;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_req   <= 1'b0;
      r_vec   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_irq_p <= irq_src;
      r_pend  <= (r_pend & ~w_clr) | w_rise;
      r_ptr   <= w_ptr_n;
      r_sel   <= w_sel_n;
      r_req   <= w_req_n;
      r_vec   <= w_vec_n;
      r_cnt   <= w_cnt_n;
    end
  end

  assign msi_request    = r_req;
  assign msi_vector_num = r_vec;
  assign pending_o      = r_pend;

endmodule
